// File: rtl/irq_aggregator_pkg.sv
// Purpose: shared register map and widths for the interrupt aggregator.
// Latency: n/a (constants only).
// Backpressure: n/a.
package irq_aggregator_pkg;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 3;
   localparam int ID_W   = 4;

   localparam logic [ADDR_W-1:0] ADDR_PENDING  = 3'd0;
   localparam logic [ADDR_W-1:0] ADDR_MASK     = 3'd1;
   localparam logic [ADDR_W-1:0] ADDR_EDGE_SEL = 3'd2;
   localparam logic [ADDR_W-1:0] ADDR_FORCE    = 3'd3;
   localparam logic [ADDR_W-1:0] ADDR_ACTIVE   = 3'd4;
   localparam logic [ADDR_W-1:0] ADDR_RAW      = 3'd5;
endpackage

// File: rtl/irq_aggregator_if.sv
// Purpose: Avalon-MM register port of the interrupt aggregator.
// Latency: readdata valid one clock after address is presented.
// Backpressure: none, zero wait-state slave.
interface irq_aggregator_if;
   import irq_aggregator_pkg::*;

   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              write_n;
   logic [DATA_W-1:0] writedata;
   logic [DATA_W-1:0] readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/irq_aggregator_prio_enc.sv
// Purpose: fixed-priority encoder, lowest set index wins.
// Latency: combinational.
// Backpressure: n/a.
module irq_prio_enc
   import irq_aggregator_pkg::*;
#(
   parameter int N = 16
) (
   input  logic [N-1:0]    req,
   output logic            valid,
   output logic [ID_W-1:0] id
);

   // Scan from the top down so the lowest requesting index is left in id.
   always_comb begin
      valid = |req;
      id    = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) id = ID_W'(i);
      end
   end

endmodule

// File: rtl/irq_aggregator.sv
// Purpose: merge NUM_SRC irq lines into one CPU irq + winning id, with Avalon-MM control regs.
// Latency: source edge -> pending 1 clk -> irq/irq_id 1 clk more (plus SYNC_STAGES); reads 1 clk.
// Backpressure: none; writes complete in the cycle presented, reads never stall.
module irq_aggregator
   import irq_aggregator_pkg::*;
#(
   parameter int                 NUM_SRC     = 16,
   parameter int                 SYNC_STAGES = 0,
   parameter logic [NUM_SRC-1:0] RESET_MASK  = '0
) (
   input  logic               clk,
   input  logic               reset_n,
   irq_aggregator_if.slave    bus,
   input  logic [NUM_SRC-1:0] irq_in,
   output logic               irq,
   output logic [ID_W-1:0]    irq_id
);

   logic [NUM_SRC-1:0] irq_s;
   logic [NUM_SRC-1:0] irq_s_d;
   logic [NUM_SRC-1:0] pend_e_q;
   logic [NUM_SRC-1:0] mask_q;
   logic [NUM_SRC-1:0] esel_q;
   logic [DATA_W-1:0]  readdata_q;

   // Optional synchronizer chain for sources from foreign clock domains.
   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign irq_s = irq_in;
      end else begin : g_sync
         logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
         // Shift raw levels through SYNC_STAGES flops.
         always_ff @(posedge clk) begin
            if (!reset_n) begin
               for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            end else begin
               sync_q[0] <= irq_in;
               for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            end
         end
         assign irq_s = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   // Register write decode; writedata above NUM_SRC is dropped here.
   logic               wr;
   logic [NUM_SRC-1:0] wd;
   logic [NUM_SRC-1:0] w1c;
   logic [NUM_SRC-1:0] frc;
   logic               mask_wr;
   logic               esel_wr;
   logic [NUM_SRC-1:0] esel_chg;

   assign wr       = bus.chipselect & ~bus.write_n;
   assign wd       = bus.writedata[NUM_SRC-1:0];
   assign w1c      = (wr && bus.address == ADDR_PENDING) ? wd : '0;
   assign frc      = (wr && bus.address == ADDR_FORCE)   ? wd : '0;
   assign mask_wr  = wr && bus.address == ADDR_MASK;
   assign esel_wr  = wr && bus.address == ADDR_EDGE_SEL;
   // Bits whose mode flips lose their pending state on the write cycle.
   assign esel_chg = esel_wr ? (wd ^ esel_q) : '0;

   // Edge-mode pending lives in pend_e_q; level-mode pending is the registered input level.
   logic [NUM_SRC-1:0] edge_det;
   logic [NUM_SRC-1:0] pend_view;
   logic [NUM_SRC-1:0] pend_e_nxt;

   assign edge_det   = irq_s & ~irq_s_d;
   assign pend_view  = (esel_q & pend_e_q) | (~esel_q & irq_s_d);
   // Set (edge/force) beats same-cycle W1C; level-mode bits are held at zero.
   assign pend_e_nxt = esel_q & ~esel_chg & ((pend_e_q & ~w1c) | edge_det | frc);

   logic            act_vld;
   logic [ID_W-1:0] act_id;

   irq_prio_enc #(.N(NUM_SRC)) u_prio_enc (
      .req   (pend_view & mask_q),
      .valid (act_vld),
      .id    (act_id)
   );

   // Read mux sees pre-write state, so a read in a write cycle returns the old value.
   logic [DATA_W-1:0] rd_nxt;
   always_comb begin
      rd_nxt = '0;
      case (bus.address)
         ADDR_PENDING:  rd_nxt = DATA_W'(pend_view);
         ADDR_MASK:     rd_nxt = DATA_W'(mask_q);
         ADDR_EDGE_SEL: rd_nxt = DATA_W'(esel_q);
         ADDR_ACTIVE:   rd_nxt = {act_vld, {(DATA_W-1-ID_W){1'b0}}, act_id};
         ADDR_RAW:      rd_nxt = DATA_W'(irq_s);
         default:       rd_nxt = '0;
      endcase
   end

   // Control registers, pending state, edge history and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         irq_s_d    <= '0;
         pend_e_q   <= '0;
         mask_q     <= RESET_MASK;
         esel_q     <= '0;
         readdata_q <= '0;
         irq        <= 1'b0;
         irq_id     <= '0;
      end else begin
         irq_s_d    <= irq_s;
         pend_e_q   <= pend_e_nxt;
         if (mask_wr) mask_q <= wd;
         if (esel_wr) esel_q <= wd;
         readdata_q <= rd_nxt;
         irq        <= act_vld;
         irq_id     <= act_id;
      end
   end

   assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_irq_aggregator.sv
// Purpose: directed + random check of irq_aggregator against a per-source behavioural model.
// Latency: model is advanced on every rising edge, outputs compared 1 time unit later.
// Backpressure: n/a.
module tb_irq_aggregator;
   localparam int          NS    = 16;
   localparam logic [15:0] RMASK = 16'h0120;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [15:0]   irq_in;
   logic          irq;
   logic [3:0]    irq_id;

   irq_aggregator_if bus ();

   irq_aggregator #(.NUM_SRC(NS), .SYNC_STAGES(0), .RESET_MASK(RMASK)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus),
      .irq_in  (irq_in),
      .irq     (irq),
      .irq_id  (irq_id)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: one boolean per source for each architectural quantity.
   bit          m_prev [NS];
   bit          m_pe   [NS];
   bit          m_mask [NS];
   bit          m_esel [NS];
   bit          m_irq;
   int          m_id;
   logic [15:0] m_rd;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      bit          view [NS];
      int          win;
      logic [15:0] rdv;
      bit          wr;
      bit          edge_i, npe;
      win = -1;
      for (int i = 0; i < NS; i++) begin
         view[i] = m_esel[i] ? m_pe[i] : m_prev[i];
         if (view[i] && m_mask[i] && win < 0) win = i;
      end
      rdv = '0;
      case (bus.address)
         3'd0: for (int i = 0; i < NS; i++) rdv[i] = view[i];
         3'd1: for (int i = 0; i < NS; i++) rdv[i] = m_mask[i];
         3'd2: for (int i = 0; i < NS; i++) rdv[i] = m_esel[i];
         3'd4: rdv = (win >= 0) ? (16'h8000 + 16'(win)) : 16'h0000;
         3'd5: rdv = irq_in;
         default: rdv = '0;
      endcase
      if (!reset_n) begin
         for (int i = 0; i < NS; i++) begin
            m_prev[i] = 0; m_pe[i] = 0; m_esel[i] = 0; m_mask[i] = RMASK[i];
         end
         m_irq = 0; m_id = 0; m_rd = '0;
      end else begin
         wr = bus.chipselect && !bus.write_n;
         for (int i = 0; i < NS; i++) begin
            edge_i = irq_in[i] && !m_prev[i];
            if (wr && bus.address == 3'd2 && bus.writedata[i] != m_esel[i]) npe = 0;
            else if (m_esel[i])
               npe = (m_pe[i] && !(wr && bus.address == 3'd0 && bus.writedata[i])) || edge_i ||
                     (wr && bus.address == 3'd3 && bus.writedata[i]);
            else npe = 0;
            m_pe[i]   = npe;
            m_prev[i] = irq_in[i];
            if (wr && bus.address == 3'd1) m_mask[i] = bus.writedata[i];
            if (wr && bus.address == 3'd2) m_esel[i] = bus.writedata[i];
         end
         m_irq = (win >= 0);
         m_id  = (win >= 0) ? win : 0;
         m_rd  = rdv;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("cyc_irq", {15'b0, irq}, {15'b0, m_irq});
      chk("cyc_irq_id", {12'b0, irq_id}, 16'(m_id));
      chk("cyc_readdata", bus.readdata, m_rd);
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
      tick();
      bus.chipselect = 1'b0; bus.write_n = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, output logic [15:0] v);
      bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
      tick();
      v = bus.readdata;
      bus.chipselect = 1'b0;
   endtask

   logic [15:0] v;

   initial begin
      for (int i = 0; i < NS; i++) begin
         m_prev[i] = 0; m_pe[i] = 0; m_mask[i] = 0; m_esel[i] = 0;
      end
      m_irq = 0; m_id = 0; m_rd = '0;
      bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
      reset_n = 1'b0; irq_in = 16'hFFFF;
      @(negedge clk);

      // Reset with all sources high
      tick(); tick();
      chk("rst_irq", {15'b0, irq}, 16'h0000);
      chk("rst_readdata", bus.readdata, 16'h0000);
      chk("rst_irq_id", {12'b0, irq_id}, 16'h0000);

      // Release with sources still high: level view picks up bit 5 of RESET_MASK
      reset_n = 1'b1;
      rd(3'd1, v);
      chk("rst_mask", v, RMASK);
      tick();
      chk("release_irq", {15'b0, irq}, 16'h0001);
      chk("release_id", {12'b0, irq_id}, 16'h0005);
      irq_in = '0;
      tick(); tick();
      chk("release_drop_irq", {15'b0, irq}, 16'h0000);

      // Edge capture on bit 0
      wr(3'd2, 16'h0001);
      wr(3'd1, 16'h0001);
      irq_in = 16'h0001; tick();
      irq_in = 16'h0000; tick();
      chk("edge_irq", {15'b0, irq}, 16'h0001);
      rd(3'd0, v);
      chk("edge_pending", v, 16'h0001);
      wr(3'd0, 16'h0001);
      tick();
      chk("edge_w1c_irq", {15'b0, irq}, 16'h0000);

      // W1C colliding with a new edge: set wins
      irq_in = 16'h0001;
      wr(3'd0, 16'h0001);
      irq_in = 16'h0000;
      rd(3'd0, v);
      chk("collide_pending", v, 16'h0001);
      wr(3'd0, 16'h0001);
      tick();

      // Level mode on bit 2
      wr(3'd2, 16'h0000);
      wr(3'd1, 16'h0004);
      irq_in = 16'h0004;
      tick(); tick(); tick();
      chk("level_irq", {15'b0, irq}, 16'h0001);
      wr(3'd0, 16'h0004);
      tick();
      chk("level_w1c_irq", {15'b0, irq}, 16'h0001);
      rd(3'd0, v);
      chk("level_pending", v, 16'h0004);
      irq_in = 16'h0000;
      tick(); tick();
      chk("level_drop_irq", {15'b0, irq}, 16'h0000);

      // Priority between bits 5 and 9
      wr(3'd2, 16'h0220);
      wr(3'd1, 16'hFFFF);
      irq_in = 16'h0220; tick();
      irq_in = 16'h0000; tick();
      rd(3'd4, v);
      chk("prio_active_5", v, 16'h8005);
      wr(3'd0, 16'h0020);
      rd(3'd4, v);
      chk("prio_active_9", v, 16'h8009);
      chk("prio_irq_id", {12'b0, irq_id}, 16'h0009);

      // Masked force, then unmask
      wr(3'd1, 16'h0000);
      wr(3'd2, 16'h0008);
      wr(3'd3, 16'h0008);
      rd(3'd0, v);
      chk("force_pending", v, 16'h0008);
      chk("force_masked_irq", {15'b0, irq}, 16'h0000);
      wr(3'd1, 16'h0008);
      tick();
      chk("unmask_irq", {15'b0, irq}, 16'h0001);
      chk("unmask_id", {12'b0, irq_id}, 16'h0003);
      rd(3'd3, v);
      chk("force_reads0", v, 16'h0000);
      wr(3'd7, 16'hFFFF);
      rd(3'd6, v);
      chk("addr6_reads0", v, 16'h0000);
      rd(3'd1, v);
      chk("addr7_ignored", v, 16'h0008);
      irq_in = 16'hA5A5;
      rd(3'd5, v);
      chk("raw", v, 16'hA5A5);
      irq_in = 16'h0000;

      // Random traffic against the model
      for (int n = 0; n < 600; n++) begin
         reset_n         = ($urandom_range(0, 99) != 0);
         bus.address     = 3'($urandom);
         bus.chipselect  = 1'($urandom);
         bus.write_n     = ($urandom_range(0, 2) != 0);
         bus.writedata   = 16'($urandom);
         irq_in          = 16'($urandom & $urandom);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
